modinv_binary_rt: RTL and testbench

- Parametrised, handshaked successor of the fixed-modulus binary modular inverter in the EC point add/double datapath.
- Computes r = a^-1 mod m, where a is a 2W-bit operand (for example an unreduced product) and m is an odd W-bit modulus supplied at run time.
- Reduces a mod m first, then runs the binary extended Euclidean algorithm, one step per cycle.
- Flags non-invertible inputs instead of hanging, and adds ready/start/done handshaking.

---
 rtl/modinv_binary_rt_pkg.sv | 23 ++
 rtl/modinv_binary_rt_if.sv | 23 ++
 rtl/modinv_binary_rt_half_sub.sv | 18 +
 rtl/modinv_binary_rt_reg.sv | 15 +
 rtl/modinv_binary_rt.sv | 140 ++++++++++++++
 tb/tb_modinv_binary_rt.sv | 190 +++++++++++++++++++
 6 files changed

// File: rtl/modinv_binary_rt_pkg.sv
// Shared types and constants for the run-time modulus binary inverter.
// Holds the FSM encoding, a width helper and the secp256k1 field prime.
package modinv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REDUCE,
      INIT,
      LOOP,
      FIN
   } state_t;

   localparam logic [255:0] SECP256K1_P =
      256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/modinv_binary_rt_if.sv
// Request/response bundle of the modular inverter.
// The master drives operands and start; the slave returns status and result.
interface modinv_binary_rt_if #(parameter int W = 256);

   logic             start;
   logic [2*W-1:0]   a;
   logic [W-1:0]     m;
   logic             ready;
   logic             done;
   logic [W-1:0]     result;
   logic             err;

   modport master (
      output start, a, m,
      input  ready, done, result, err
   );

   modport slave (
      input  start, a, m,
      output ready, done, result, err
   );

endinterface

// File: rtl/modinv_binary_rt_half_sub.sv
// Combinational helpers for the x1/x2 updates: halving and subtraction mod m.
// Inputs are assumed already reduced (x, y < m), so one correction suffices.
module mod_half_sub #(parameter int W = 256) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] m,
   output logic [W-1:0] half,
   output logic [W-1:0] diff
);

   logic [W:0] sum;

   // odd x: add the odd modulus first so the sum is even and divides exactly
   assign sum  = {1'b0, x} + (x[0] ? {1'b0, m} : '0);
   assign half = W'(sum >> 1);
   assign diff = (x >= y) ? (x - y) : (x - y + m);

endmodule

// File: rtl/modinv_binary_rt_reg.sv
// Plain storage register with synchronous active-high clear.
// Every state element of the inverter is one of these.
module reg_256 #(parameter int WIDTH = 256) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge Clk) begin
      if (Reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/modinv_binary_rt.sv
// Modular inverter r = a^-1 mod m with run-time odd modulus.
// Reduces the 2W-bit operand bit-serially, then runs binary extended Euclid.
module modinv_binary_rt
   import modinv_pkg::*;
#(parameter int W = 256) (
   input logic               Clk,
   input logic               Reset,
   modinv_binary_rt_if.slave bus
);

   localparam int AW = clog2(2 * W);
   localparam int CW = AW + 1;

   logic [2:0]     st_raw;
   state_t         state_q, state_d;
   logic [2*W-1:0] a_d, a_q;
   logic [W-1:0]   m_d, m_q;
   logic [W:0]     rem_d, rem_q;
   logic [CW-1:0]  cnt_d, cnt_q;
   logic [W-1:0]   u_d, u_q, v_d, v_q;
   logic [W-1:0]   x1_d, x1_q, x2_d, x2_q;
   logic [W-1:0]   result_d, result_q;
   logic           err_d, err_q;
   logic           done_d, done_q;
   logic [W-1:0]   h1, d1, h2, d2;
   logic [AW-1:0]  bit_idx;
   logic [W:0]     t;

   assign state_q = state_t'(st_raw);

   reg_256 #(3)     u_st  (.Clk, .Reset, .d(state_d),  .q(st_raw));
   reg_256 #(2*W)   u_a   (.Clk, .Reset, .d(a_d),      .q(a_q));
   reg_256 #(W)     u_m   (.Clk, .Reset, .d(m_d),      .q(m_q));
   reg_256 #(W+1)   u_rem (.Clk, .Reset, .d(rem_d),    .q(rem_q));
   reg_256 #(CW)    u_cnt (.Clk, .Reset, .d(cnt_d),    .q(cnt_q));
   reg_256 #(W)     u_u   (.Clk, .Reset, .d(u_d),      .q(u_q));
   reg_256 #(W)     u_v   (.Clk, .Reset, .d(v_d),      .q(v_q));
   reg_256 #(W)     u_x1  (.Clk, .Reset, .d(x1_d),     .q(x1_q));
   reg_256 #(W)     u_x2  (.Clk, .Reset, .d(x2_d),     .q(x2_q));
   reg_256 #(W)     u_res (.Clk, .Reset, .d(result_d), .q(result_q));
   reg_256 #(1)     u_err (.Clk, .Reset, .d(err_d),    .q(err_q));
   reg_256 #(1)     u_dn  (.Clk, .Reset, .d(done_d),   .q(done_q));

   mod_half_sub #(W) u_hs1 (.x(x1_q), .y(x2_q), .m(m_q), .half(h1), .diff(d1));
   mod_half_sub #(W) u_hs2 (.x(x2_q), .y(x1_q), .m(m_q), .half(h2), .diff(d2));

   // MSB-first walk over the latched operand
   assign bit_idx = AW'(2 * W - 1) - cnt_q[AW-1:0];
   assign t       = {rem_q[W-1:0], a_q[bit_idx]};

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      m_d      = m_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      u_d      = u_q;
      v_d      = v_q;
      x1_d     = x1_q;
      x2_d     = x2_q;
      result_d = result_q;
      err_d    = err_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d   = bus.a;
               m_d   = bus.m;
               rem_d = '0;
               cnt_d = '0;
               if (!bus.m[0] || bus.m < W'(3)) begin
                  state_d  = FIN;
                  result_d = '0;
                  err_d    = 1'b1;
                  done_d   = 1'b1;
               end else begin
                  state_d = REDUCE;
               end
            end
         end
         REDUCE: begin
            rem_d = (t >= {1'b0, m_q}) ? (t - {1'b0, m_q}) : t;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(2 * W - 1)) state_d = INIT;
         end
         INIT: begin
            u_d  = rem_q[W-1:0];
            v_d  = m_q;
            x1_d = W'(1);
            x2_d = '0;
            if (rem_q == '0) begin
               state_d  = FIN;
               result_d = '0;
               err_d    = 1'b1;
               done_d   = 1'b1;
            end else begin
               state_d = LOOP;
            end
         end
         LOOP: begin
            if (u_q == W'(1)) begin
               state_d  = FIN;
               result_d = x1_q;
               err_d    = 1'b0;
               done_d   = 1'b1;
            end else if (v_q == W'(1)) begin
               state_d  = FIN;
               result_d = x2_q;
               err_d    = 1'b0;
               done_d   = 1'b1;
            end else if (u_q == '0 || v_q == '0) begin
               state_d  = FIN;
               result_d = '0;
               err_d    = 1'b1;
               done_d   = 1'b1;
            end else if (!u_q[0]) begin
               u_d  = u_q >> 1;
               x1_d = h1;
            end else if (!v_q[0]) begin
               v_d  = v_q >> 1;
               x2_d = h2;
            end else if (u_q >= v_q) begin
               u_d  = u_q - v_q;
               x1_d = d1;
            end else begin
               v_d  = v_q - u_q;
               x2_d = d2;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.ready  = (state_q == IDLE);
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_modinv_binary_rt.sv
// Directed and exhaustive checks of modinv_binary_rt at W=256 and W=8.
// Expected results are queued at start and popped when done is seen.
module tb_modinv_binary_rt;
   import modinv_pkg::*;

   typedef struct {
      logic [255:0] res;
      logic         err;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   int   errs = 0;
   int   checks = 0;
   int   max_lat = 0;
   exp_t sb8[$];
   exp_t sb256[$];

   always #5 Clk = ~Clk;

   modinv_binary_rt_if #(.W(256)) i256 ();
   modinv_binary_rt_if #(.W(8))   i8 ();

   modinv_binary_rt #(.W(256)) u256 (.Clk(Clk), .Reset(Reset), .bus(i256));
   modinv_binary_rt #(.W(8))   u8   (.Clk(Clk), .Reset(Reset), .bus(i8));

   function automatic void chk(string tag, logic [255:0] obs, logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h exp %0h", tag, obs, exp);
      end
   endfunction

   function automatic exp_t ref_inv(int a, int m);
      exp_t e;
      e.res = '0;
      e.err = 1'b1;
      if (m >= 3 && (m % 2) == 1) begin
         for (int r = 1; r < m; r++) begin
            if (((a % m) * r) % m == 1) begin
               e.res = 256'(r);
               e.err = 1'b0;
               break;
            end
         end
      end
      return e;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic run8(input logic [15:0] a, input logic [7:0] m,
                       input logic [7:0] er, input logic ee,
                       input int xlat, input string tag);
      int   lat;
      exp_t e;
      for (int i = 0; i < 400 && i8.ready !== 1'b1; i++) step();
      chk({tag, " ready"}, 256'(i8.ready), 256'(1));
      i8.a     = a;
      i8.m     = m;
      i8.start = 1'b1;
      sb8.push_back('{256'(er), ee});
      lat = 0;
      do begin
         step();
         i8.start = 1'b0;
         lat++;
      end while (i8.done !== 1'b1 && lat < 200);
      chk({tag, " done"}, 256'(i8.done), 256'(1));
      e = sb8.pop_front();
      chk({tag, " result"}, 256'(i8.result), e.res);
      chk({tag, " err"}, 256'(i8.err), 256'(e.err));
      if (xlat > 0) chk({tag, " latency"}, 256'(lat), 256'(xlat));
      else          chk({tag, " lat<=6W+2"}, 256'(lat <= 6 * 8 + 2), 256'(1));
      if (lat > max_lat) max_lat = lat;
      step();
      chk({tag, " ready after FIN"}, 256'(i8.ready), 256'(1));
      chk({tag, " done one cycle"}, 256'(i8.done), 256'(0));
   endtask

   initial begin
      int   lat;
      int   ndone;
      exp_t e;
      i8.start   = 1'b0;
      i8.a       = '0;
      i8.m       = '0;
      i256.start = 1'b0;
      i256.a     = '0;
      i256.m     = '0;
      repeat (3) step();
      Reset = 1'b0;
      chk("rst ready", 256'(i8.ready), 256'(1));
      chk("rst done", 256'(i8.done), 256'(0));
      chk("rst result", 256'(i8.result), 256'(0));
      chk("rst err", 256'(i8.err), 256'(0));
      chk("rst ready256", 256'(i256.ready), 256'(1));

      // secp256k1: inverse of 2
      i256.a     = 512'd2;
      i256.m     = SECP256K1_P;
      i256.start = 1'b1;
      sb256.push_back('{256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18, 1'b0});
      lat = 0;
      do begin
         step();
         i256.start = 1'b0;
         lat++;
      end while (i256.done !== 1'b1 && lat < 2000);
      chk("p256 done", 256'(i256.done), 256'(1));
      e = sb256.pop_front();
      chk("p256 result", i256.result, e.res);
      chk("p256 err", 256'(i256.err), 256'(e.err));
      chk("p256 lat<=6W+2", 256'(lat <= 6 * 256 + 2), 256'(1));

      run8(16'h0100, 8'd11, 8'd4, 1'b0, 0, "m11 a256");
      run8(16'd1, 8'd11, 8'd1, 1'b0, 0, "m11 a1");
      run8(16'd10, 8'd11, 8'd10, 1'b0, 0, "m11 a10");
      run8(16'd6, 8'd9, 8'd0, 1'b1, 0, "m9 a6");
      run8(16'd0, 8'd9, 8'd0, 1'b1, 2 * 8 + 2, "m9 a0");
      run8(16'd5, 8'd10, 8'd0, 1'b1, 1, "m10 even");
      run8(16'd5, 8'd1, 8'd0, 1'b1, 1, "m1");
      run8(16'hFFFF, 8'd7, 8'd1, 1'b0, 0, "m7 aFFFF");

      // start held high while busy, operands changing: one done, old operands
      i8.a     = 16'd3;
      i8.m     = 8'd11;
      i8.start = 1'b1;
      sb8.push_back('{256'd4, 1'b0});
      ndone = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         i8.a = 16'd5;
         i8.m = 8'd13;
         if (i8.done === 1'b1) begin
            ndone++;
            i8.start = 1'b0;
            break;
         end
      end
      e = sb8.pop_front();
      chk("hold result", 256'(i8.result), e.res);
      chk("hold err", 256'(i8.err), 256'(e.err));
      repeat (6) begin
         step();
         if (i8.done === 1'b1) ndone++;
      end
      chk("hold one done", 256'(ndone), 256'(1));

      // reset in the first LOOP cycle aborts without a done pulse
      i8.a     = 16'd3;
      i8.m     = 8'd251;
      i8.start = 1'b1;
      step();
      i8.start = 1'b0;
      ndone = 0;
      repeat (17) begin
         step();
         if (i8.done === 1'b1) ndone++;
      end
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      chk("mid rst ready", 256'(i8.ready), 256'(1));
      chk("mid rst result", 256'(i8.result), 256'(0));
      chk("mid rst err", 256'(i8.err), 256'(0));
      repeat (4) begin
         step();
         if (i8.done === 1'b1) ndone++;
      end
      chk("mid rst no done", 256'(ndone), 256'(0));
      run8(16'd3, 8'd251, 8'd84, 1'b0, 0, "post rst");

      max_lat = 0;
      for (int a = 1; a <= 250; a++) begin
         e = ref_inv(a, 251);
         run8(16'(a), 8'd251, e.res[7:0], e.err, 0, "ex251");
         chk("ex251 a*r mod m", 256'((a * int'(i8.result)) % 251), 256'(1));
      end
      chk("ex251 max lat", 256'(max_lat <= 6 * 8 + 2), 256'(1));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
